// File: rtl/systolic_tile_sequencer.sv
// -----------------------------------------------------------------------------
// systolic_tile_sequencer
//
// Sequences one tile job on an N x N systolic array (N = BLOCK_SIZE):
//   clear accumulators -> stream N operand slices -> drain the array for 2N-1
//   cycles -> report completion -> wait for write-back grant -> write back
//   N result rows of C.
//
// Handshake with the block manager:
//   start_systolic is a request that is sampled only while the sequencer is
//   idle (busy=0). The six block indices must be valid in the same cycle.
//   systolic_done is a single-cycle completion pulse. accumulate_result is the
//   grant; it is sampled only in the DONE cycle and while waiting afterwards,
//   and the first sampled 1 starts the write-back burst. A request or a grant
//   seen in any other state is dropped, never queued.
//
// Parameters:
//   BLOCK_SIZE  tile edge N, power of two, 4..64
//   K_W         width of feed_k / wb_row, defaults to $clog2(BLOCK_SIZE)
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   start_systolic           job request
//   a/b/c_row_idx, _col_idx  2-bit block coordinates sampled with the request
//   systolic_done            one-cycle pulse when array results are complete
//   accumulate_result        grant to write results back
//   busy                     high in every state except IDLE
//   array_clear              one-cycle pulse zeroing the PE accumulators
//   feed_valid, feed_k       operand stream strobe and slice index
//   a_blk, b_blk, c_blk      latched {row,col} of the A, B and C tiles
//   wb_valid, wb_row         C write-back strobe and row index
//   wb_accumulate            1: add into C, 0: overwrite C (first k-term)
//   acc_timeout              sticky watchdog error flag
//   fsm_state                current FSM state, for debug/observation
//
// Configuration:
//   TILE_SEQ_ACC_TIMEOUT_EN  when defined, a job abandons the wait for the
//                            write-back grant after 256 cycles in WAIT_ACC,
//                            sets acc_timeout (held until rst) and returns
//                            to IDLE without writing back. When undefined,
//                            the wait is unbounded and acc_timeout is 0.
// -----------------------------------------------------------------------------
module systolic_tile_sequencer #(
  parameter int BLOCK_SIZE = 64,
  parameter int K_W        = $clog2(BLOCK_SIZE)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_systolic,
  input  logic [1:0]     a_row_idx,
  input  logic [1:0]     a_col_idx,
  input  logic [1:0]     b_row_idx,
  input  logic [1:0]     b_col_idx,
  input  logic [1:0]     c_row_idx,
  input  logic [1:0]     c_col_idx,
  output logic           systolic_done,
  input  logic           accumulate_result,
  output logic           busy,
  output logic           array_clear,
  output logic           feed_valid,
  output logic [K_W-1:0] feed_k,
  output logic [3:0]     a_blk,
  output logic [3:0]     b_blk,
  output logic [3:0]     c_blk,
  output logic           wb_valid,
  output logic [K_W-1:0] wb_row,
  output logic           wb_accumulate,
  output logic           acc_timeout,
  output logic [2:0]     fsm_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FEED     = 3'd1,
    FLUSH    = 3'd2,
    DONE     = 3'd3,
    WAIT_ACC = 3'd4,
    WB       = 3'd5
  } state_t;

  // The phase counter needs one bit more than K_W because FLUSH lasts 2N-1
  // cycles. FEED and WB only ever count to N-1, so the low K_W bits are
  // exported directly and never carry into the extra bit.
  localparam int              CW         = K_W + 1;
  localparam logic [CW-1:0]   LAST_SLICE = CW'(BLOCK_SIZE - 1);
  localparam logic [CW-1:0]   LAST_FLUSH = CW'(2 * BLOCK_SIZE - 2);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          latch_en;
  logic          timeout_fire;

`ifdef TILE_SEQ_ACC_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       timeout_q;
`endif

  assign fsm_state = state;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    busy          = (state != IDLE);
    array_clear   = 1'b0;
    feed_valid    = 1'b0;
    feed_k        = '0;
    systolic_done = 1'b0;
    wb_valid      = 1'b0;
    wb_row        = '0;
    wb_accumulate = 1'b0;
    latch_en      = 1'b0;
    timeout_fire  = 1'b0;

    case (state)
      IDLE: begin
        // Clear is issued in the request cycle so the PEs are zero before the
        // first operand slice arrives. A request coinciding with reset is
        // dropped, so no clear is issued for it either.
        if (start_systolic && !rst) begin
          array_clear = 1'b1;
          latch_en    = 1'b1;
          cnt_next    = '0;
          state_next  = FEED;
        end
      end

      FEED: begin
        feed_valid = 1'b1;
        feed_k     = cnt[K_W-1:0];
        if (cnt == LAST_SLICE) begin
          cnt_next   = '0;
          state_next = FLUSH;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      FLUSH: begin
        // The last slice needs 2N-1 more cycles to reach the far corner PE.
        if (cnt == LAST_FLUSH) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      DONE: begin
        systolic_done = 1'b1;
        cnt_next      = '0;
        if (accumulate_result) begin
          state_next = WB;
        end else begin
          state_next = WAIT_ACC;
        end
      end

      WAIT_ACC: begin
        cnt_next = '0;
        if (accumulate_result) begin
          state_next = WB;
`ifdef TILE_SEQ_ACC_TIMEOUT_EN
        end else if (wait_cnt == 8'd255) begin
          // 256th consecutive WAIT_ACC cycle without a grant.
          timeout_fire = 1'b1;
          state_next   = IDLE;
`endif
        end
      end

      WB: begin
        wb_valid      = 1'b1;
        wb_row        = cnt[K_W-1:0];
        // Column 0 of A is the first k-term of C, so C is overwritten rather
        // than accumulated into.
        wb_accumulate = (a_blk[1:0] != 2'd0);
        if (cnt == LAST_SLICE) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, phase counter and latched block coordinates
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_blk <= 4'd0;
      b_blk <= 4'd0;
      c_blk <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (latch_en) begin
        a_blk <= {a_row_idx, a_col_idx};
        b_blk <= {b_row_idx, b_col_idx};
        c_blk <= {c_row_idx, c_col_idx};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write-back grant watchdog
  // ---------------------------------------------------------------------------
`ifdef TILE_SEQ_ACC_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      // Counts WAIT_ACC cycles already spent; restarts every time the state
      // is entered.
      if (state == WAIT_ACC) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end
      if (timeout_fire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign acc_timeout = timeout_q;
`else
  assign acc_timeout = 1'b0;

  logic unused_timeout;
  assign unused_timeout = timeout_fire;
`endif

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// -----------------------------------------------------------------------------
// tb_systolic_tile_sequencer
//
// Bench for systolic_tile_sequencer with BLOCK_SIZE=4. Every cycle goes
// through one driver task that applies the inputs, compares all outputs with
// a job-timeline reference model and then advances that model. The model
// only knows the start cycle of the current job and the cycle of its grant;
// expected outputs are plain arithmetic on the distance from those cycles.
// On top of that a job table, hand-written sequences and a random run check
// job-level results against constants.
// -----------------------------------------------------------------------------
module tb_systolic_tile_sequencer;

  localparam int N  = 4;
  localparam int KW = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic          clk;
  logic          rst;
  logic          start_systolic;
  logic [1:0]    a_row_idx, a_col_idx, b_row_idx, b_col_idx, c_row_idx, c_col_idx;
  logic          systolic_done;
  logic          accumulate_result;
  logic          busy;
  logic          array_clear;
  logic          feed_valid;
  logic [KW-1:0] feed_k;
  logic [3:0]    a_blk, b_blk, c_blk;
  logic          wb_valid;
  logic [KW-1:0] wb_row;
  logic          wb_accumulate;
  logic          acc_timeout;
  logic [2:0]    fsm_state;

  systolic_tile_sequencer #(.BLOCK_SIZE(N)) dut (
    .clk               (clk),
    .rst               (rst),
    .start_systolic    (start_systolic),
    .a_row_idx         (a_row_idx),
    .a_col_idx         (a_col_idx),
    .b_row_idx         (b_row_idx),
    .b_col_idx         (b_col_idx),
    .c_row_idx         (c_row_idx),
    .c_col_idx         (c_col_idx),
    .systolic_done     (systolic_done),
    .accumulate_result (accumulate_result),
    .busy              (busy),
    .array_clear       (array_clear),
    .feed_valid        (feed_valid),
    .feed_k            (feed_k),
    .a_blk             (a_blk),
    .b_blk             (b_blk),
    .c_blk             (c_blk),
    .wb_valid          (wb_valid),
    .wb_row            (wb_row),
    .wb_accumulate     (wb_accumulate),
    .acc_timeout       (acc_timeout),
    .fsm_state         (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: one job timeline.
  bit         m_idle;
  int         m_t0;      // cycle in which the request was accepted
  int         m_g;       // cycle in which the grant was accepted, -1 if none
  logic [3:0] m_a, m_b, m_c;
  bit         m_to;

  // Observations.
  int   done_count = 0;
  int   last_done  = -1;
  int   wb_count   = 0;
  logic last_wb_acc;
  logic wb_acc_log[$];
  logic exp_q[$];

  typedef struct {
    logic [1:0] ar, ac, br, bc, cr, cc;
    int         gap;     // cycles between systolic_done and the grant
    bit         noise;   // requests/grants during FEED and FLUSH
    logic [3:0] ea, eb, ec;
    logic       ewb;
  } job_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle with model check and model update
  // ---------------------------------------------------------------------------
  task automatic cycle(input logic s,
                       input logic [1:0] ar, input logic [1:0] ac,
                       input logic [1:0] br, input logic [1:0] bc,
                       input logic [1:0] cr, input logic [1:0] cc,
                       input logic acc, input logic r);
    int            rel;
    int            wrel;
    logic          e_fv, e_done, e_wb, e_clear, e_wacc;
    logic [KW-1:0] e_fk, e_row;
    @(negedge clk);
    start_systolic    = s;
    a_row_idx         = ar;
    a_col_idx         = ac;
    b_row_idx         = br;
    b_col_idx         = bc;
    c_row_idx         = cr;
    c_col_idx         = cc;
    accumulate_result = acc;
    rst               = r;
    #1;

    rel     = cyc - m_t0;
    wrel    = cyc - m_g;
    e_clear = m_idle && s && !r;
    e_fv    = !m_idle && rel >= 1 && rel <= N;
    e_fk    = e_fv ? KW'(rel - 1) : '0;
    e_done  = !m_idle && rel == 3 * N;
    e_wb    = !m_idle && m_g >= 0 && wrel >= 1 && wrel <= N;
    e_row   = e_wb ? KW'(wrel - 1) : '0;
    e_wacc  = e_wb && (m_a[1:0] != 2'd0);

    chk("busy",          32'(busy),          32'(!m_idle));
    chk("array_clear",   32'(array_clear),   32'(e_clear));
    chk("feed_valid",    32'(feed_valid),    32'(e_fv));
    chk("feed_k",        32'(feed_k),        32'(e_fk));
    chk("systolic_done", 32'(systolic_done), 32'(e_done));
    chk("wb_valid",      32'(wb_valid),      32'(e_wb));
    chk("wb_row",        32'(wb_row),        32'(e_row));
    chk("wb_accumulate", 32'(wb_accumulate), 32'(e_wacc));
    chk("a_blk",         32'(a_blk),         32'(m_a));
    chk("b_blk",         32'(b_blk),         32'(m_b));
    chk("c_blk",         32'(c_blk),         32'(m_c));
    chk("acc_timeout",   32'(acc_timeout),   32'(m_to));

    if (systolic_done === 1'b1) begin
      done_count++;
      last_done = cyc;
    end
    if (wb_valid === 1'b1) begin
      wb_count++;
      last_wb_acc = wb_accumulate;
      if (wb_row == '0) wb_acc_log.push_back(wb_accumulate);
    end

    if (r) begin
      m_idle = 1;
      m_g    = -1;
      m_a    = '0;
      m_b    = '0;
      m_c    = '0;
      m_to   = 0;
    end else if (m_idle) begin
      if (s) begin
        m_idle = 0;
        m_t0   = cyc;
        m_g    = -1;
        m_a    = {ar, ac};
        m_b    = {br, bc};
        m_c    = {cr, cc};
      end
    end else if (m_g >= 0) begin
      if (wrel == N) m_idle = 1;
    end else if (rel >= 3 * N && acc) begin
      m_g = cyc;
    end else begin
`ifdef TILE_SEQ_ACC_TIMEOUT_EN
      if (rel == 3 * N + 256) begin
        m_idle = 1;
        m_to   = 1;
      end
`endif
    end
    cyc++;
  endtask

  task automatic idle_cycle(input logic acc);
    cycle(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, acc, 1'b0);
  endtask

  task automatic reset_cycle();
    cycle(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);
  endtask

  // One complete job: request, optional noise, grant `gap` cycles after done,
  // then the full write-back. Returns on the last WB cycle.
  task automatic run_job(input job_t j);
    int t0, d0, w0;
    t0 = cyc;
    d0 = done_count;
    w0 = wb_count;
    cycle(1'b1, j.ar, j.ac, j.br, j.bc, j.cr, j.cc, 1'b0, 1'b0);
    for (int rel = 1; rel <= 3 * N + j.gap + N; rel++) begin
      if (j.noise && rel < 3 * N)
        cycle(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'b0);
      else
        idle_cycle(rel == 3 * N + j.gap);
    end
    chk("job_done_count",   32'(done_count - d0), 32'd1);
    chk("job_done_latency", 32'(last_done - t0),  32'(3 * N));
    chk("job_wb_rows",      32'(wb_count - w0),   32'(N));
    chk("job_wb_acc",       32'(last_wb_acc),     32'(j.ewb));
    chk("job_a_blk",        32'(a_blk),           32'(j.ea));
    chk("job_b_blk",        32'(b_blk),           32'(j.eb));
    chk("job_c_blk",        32'(c_blk),           32'(j.ec));
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    job_t jobs[4];
    job_t bj;
    int   d0, w0;

    start_systolic    = 1'b0;
    accumulate_result = 1'b0;
    a_row_idx = 2'd0; a_col_idx = 2'd0;
    b_row_idx = 2'd0; b_col_idx = 2'd0;
    c_row_idx = 2'd0; c_col_idx = 2'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    m_idle = 1; m_t0 = 0; m_g = -1;
    m_a = '0; m_b = '0; m_c = '0; m_to = 0;

    // Reset state is checked by the model on the first cycles.
    reset_cycle();
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // Job table. A[0,1],B[1,0],C[0,0] granted one cycle after done.
    jobs[0] = '{ar:2'd0, ac:2'd1, br:2'd1, bc:2'd0, cr:2'd0, cc:2'd0,
                gap:1, noise:0, ea:4'b0001, eb:4'b0100, ec:4'b0000, ewb:1'b1};
    // Same job with a_col=0: first k-term, overwrite.
    jobs[1] = '{ar:2'd0, ac:2'd0, br:2'd1, bc:2'd0, cr:2'd0, cc:2'd0,
                gap:1, noise:0, ea:4'b0000, eb:4'b0100, ec:4'b0000, ewb:1'b0};
    // Requests and grants during FEED/FLUSH must be ignored; grant in DONE.
    jobs[2] = '{ar:2'd3, ac:2'd2, br:2'd2, bc:2'd1, cr:2'd3, cc:2'd1,
                gap:0, noise:1, ea:4'b1110, eb:4'b1001, ec:4'b1101, ewb:1'b1};
    // Noise again, longer wait for the grant.
    jobs[3] = '{ar:2'd2, ac:2'd0, br:2'd0, bc:2'd3, cr:2'd2, cc:2'd3,
                gap:5, noise:1, ea:4'b1000, eb:4'b0011, ec:4'b1011, ewb:1'b0};
    foreach (jobs[i]) begin
      run_job(jobs[i]);
      repeat (2) idle_cycle(1'b0);
    end

    // Reset during FLUSH abandons the job.
    d0 = done_count;
    w0 = wb_count;
    cycle(1'b1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 1'b0, 1'b0);
    repeat (5) idle_cycle(1'b0);
    reset_cycle();
    idle_cycle(1'b0);
    chk("rst_flush_busy",   32'(busy),       32'd0);
    chk("rst_flush_a_blk",  32'(a_blk),      32'd0);
    chk("rst_flush_fv",     32'(feed_valid), 32'd0);
    for (int i = 0; i < 20; i++) idle_cycle(1'(i % 3 == 0));
    chk("rst_flush_no_done", 32'(done_count - d0), 32'd0);
    chk("rst_flush_no_wb",   32'(wb_count - w0),   32'd0);

    // Eight back-to-back jobs over the 2x2 block product C[i][j] += A[i][k]*B[k][j].
    wb_acc_log.delete();
    exp_q.delete();
    d0 = done_count;
    w0 = wb_count;
    for (int n = 0; n < 8; n++) begin
      logic [1:0] bi, bjj, bk;
      bi  = 2'((n >> 2) & 1);
      bjj = 2'((n >> 1) & 1);
      bk  = 2'(n & 1);
      bj = '{ar:bi, ac:bk, br:bk, bc:bjj, cr:bi, cc:bjj, gap:0, noise:0,
             ea:{bi, bk}, eb:{bk, bjj}, ec:{bi, bjj}, ewb:(bk != 2'd0)};
      exp_q.push_back(bk != 2'd0);
      run_job(bj);
    end
    idle_cycle(1'b0);
    chk("b2b_done_count", 32'(done_count - d0), 32'd8);
    chk("b2b_wb_rows",    32'(wb_count - w0),   32'(8 * N));
    chk("b2b_log_size",   32'(wb_acc_log.size()), 32'd8);
    while (exp_q.size() > 0 && wb_acc_log.size() > 0)
      chk("b2b_wb_acc_pattern", 32'(wb_acc_log.pop_front()), 32'(exp_q.pop_front()));

    // Random stimulus against the model.
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 99) == 0));
    reset_cycle();
    idle_cycle(1'b0);

`ifdef TILE_SEQ_ACC_TIMEOUT_EN
    // Withheld grant: watchdog fires after 256 WAIT_ACC cycles.
    w0 = wb_count;
    cycle(1'b1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    for (int rel = 1; rel <= 3 * N + 256 + 3; rel++) idle_cycle(1'b0);
    chk("to_flag",  32'(acc_timeout), 32'd1);
    chk("to_busy",  32'(busy),        32'd0);
    chk("to_no_wb", 32'(wb_count - w0), 32'd0);
    for (int i = 0; i < 10; i++) idle_cycle(1'b1);
    chk("to_sticky", 32'(acc_timeout), 32'd1);
    reset_cycle();
    idle_cycle(1'b0);
    chk("to_cleared", 32'(acc_timeout), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_tile_sequencer.md
SYSTOLIC_TILE_SEQUENCER -- requirements
Module: systolic_tile_sequencer

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 64, giving the tile edge N (power of two, 4..64).
REQ-002 SHALL have parameter K_W, default $clog2(BLOCK_SIZE), giving the feed/row index width.
REQ-003 SHALL have port clk, input, 1, the only clock, rising-edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start_systolic, input, 1, tile-job request from the block manager.
REQ-006 SHALL have ports a_row_idx, a_col_idx, b_row_idx, b_col_idx, c_row_idx, c_col_idx, input, 2 each, block coordinates valid with start_systolic.
REQ-007 SHALL have port systolic_done, output, 1, one-cycle pulse when array results are complete.
REQ-008 SHALL have port accumulate_result, input, 1, manager grant to write results back.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have port array_clear, output, 1, one-cycle pulse zeroing PE accumulators.
REQ-011 SHALL have ports feed_valid (output, 1) and feed_k (output, K_W), operand-stream strobe and index.
REQ-012 SHALL have ports a_blk, b_blk, c_blk, output, 4 each, latched {row,col} of the A, B and C tiles.
REQ-013 SHALL have ports wb_valid (output, 1), wb_row (output, K_W) and wb_accumulate (output, 1), C write-back strobe, row and add-vs-overwrite flag.
REQ-014 SHALL have port acc_timeout, output, 1, sticky watchdog error flag.

Function
REQ-015 SHALL implement states IDLE, FEED, FLUSH, DONE, WAIT_ACC and WB.
REQ-016 SHALL, in IDLE with start_systolic=1, latch all six indices into a_blk/b_blk/c_blk, pulse array_clear in that same cycle, and enter FEED.
REQ-017 SHALL, in FEED, assert feed_valid for exactly N consecutive cycles with feed_k = 0..N-1, then enter FLUSH.
REQ-018 SHALL remain in FLUSH for exactly 2N-1 cycles with feed_valid=0, then enter DONE.
REQ-019 SHALL assert systolic_done for exactly the one DONE cycle, i.e. 3N cycles after the cycle start_systolic was sampled, then enter WAIT_ACC.
REQ-020 SHALL, in WAIT_ACC or DONE, enter WB on the first sampled accumulate_result=1.
REQ-021 SHALL, in WB, assert wb_valid for N consecutive cycles with wb_row = 0..N-1, then return to IDLE.
REQ-022 SHALL drive wb_accumulate = 0 when latched a_col = 0 (first term) and 1 otherwise, constant for the whole WB burst.
REQ-023 SHALL ignore start_systolic in every state except IDLE; held indices SHALL NOT change.
REQ-024 SHALL ignore accumulate_result in IDLE, FEED, FLUSH and WB.
REQ-025 SHALL accept a new start_systolic in the IDLE cycle immediately following the last WB cycle (back-to-back jobs).
REQ-026 SHALL keep feed_k and wb_row counters wrapping exactly at N-1 without overflow into other bits.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, force IDLE and drive busy, systolic_done, array_clear, feed_valid, wb_valid, wb_accumulate and acc_timeout to 0 and feed_k, wb_row, a_blk, b_blk, c_blk to 0.
REQ-028 SHALL, on reset mid-job, abandon the job with no further systolic_done or wb_valid pulses.

Configuration
REQ-029 SHALL, with macro TILE_SEQ_ACC_TIMEOUT_EN defined, count WAIT_ACC cycles and, at 256 cycles without accumulate_result, set acc_timeout (sticky until rst) and return to IDLE without write-back.
REQ-030 SHALL, without TILE_SEQ_ACC_TIMEOUT_EN, wait in WAIT_ACC indefinitely and tie acc_timeout to 0.

Verification (BLOCK_SIZE=4)
REQ-031 SHALL verify start_systolic pulse at cycle 0 with A[0,1],B[1,0],C[0,0] -> array_clear at 0, feed_valid cycles 1-4 (feed_k 0..3), systolic_done only at cycle 12, a_blk=4'b0001, b_blk=4'b0100, c_blk=0.
REQ-032 SHALL verify accumulate_result one cycle after systolic_done -> wb_valid 4 cycles, wb_row 0..3, wb_accumulate=1; with a_col=0 the same job yields wb_accumulate=0.
REQ-033 SHALL verify start_systolic pulses during FEED/FLUSH with different indices -> no restart, latched blk outputs unchanged, single systolic_done.
REQ-034 SHALL verify rst asserted during FLUSH -> next cycle busy=0, all outputs 0, no systolic_done afterwards.
REQ-035 SHALL verify eight back-to-back jobs following the 2x2-block sequence -> eight systolic_done pulses, eight 4-row WB bursts, wb_accumulate pattern 0,1,0,1,0,1,0,1.
REQ-036 SHALL verify, with TILE_SEQ_ACC_TIMEOUT_EN, withholding accumulate_result -> acc_timeout=1 after 256 WAIT_ACC cycles, busy=0, no wb_valid, flag held until rst.
